// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: speed ramp sequencer for a downstream PWM generator.
//
// Ports
//   i_clk       clock, all state on rising edge
//   i_rst       asynchronous active-high reset
//   i_start     one-cycle request to run, or to retarget while running
//   i_stop      one-cycle request to decelerate and stop (wins over i_start)
//   i_target    requested speed, sampled on an accepted i_start
//   i_step      speed change per ramp step (0 behaves as 1)
//   o_en        PWM enable
//   o_value     PWM speed value, kept in [MIN_VALUE, MAX_VALUE] while o_en=1
//   o_busy      high whenever not IDLE
//   o_at_speed  high in RUN
//   o_done      one-cycle pulse on STOP -> IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | output disabled, o_value=0, waiting for i_start
// RAMP  | moving o_value toward tgt by one step every STEP_DIV clocks
// RUN   | o_value == tgt, held constant
// STOP  | decelerating toward MIN_VALUE, then disable and pulse o_done
module motor_ramp_ctrl #(
  parameter int STEP_DIV  = 100000,
  parameter int MIN_VALUE = 10,
  parameter int MAX_VALUE = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_target,
  input  logic [15:0] i_step,
  output logic        o_en,
  output logic [15:0] o_value,
  output logic        o_busy,
  output logic        o_at_speed,
  output logic        o_done
);

  localparam logic [15:0] MIN16     = 16'(MIN_VALUE);
  localparam logic [15:0] MAX16     = 16'(MAX_VALUE);
  localparam logic [23:0] STEP_LAST = 24'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_RUN, S_STOP} state_t;

  state_t      state, state_nxt;
  logic [23:0] cnt;
  logic [15:0] tgt, tgt_nxt, tgt_clamp;
  logic [15:0] stp, ramp_val, stop_val, value_nxt;
  logic [16:0] sum;
  logic        step_hit, en_nxt, done_nxt;

  assign step_hit  = (state != S_IDLE) && (cnt == STEP_LAST);
  assign stp       = (i_step == 16'd0) ? 16'd1 : i_step;
  assign tgt_clamp = (i_target < MIN16) ? MIN16 :
                     (i_target > MAX16) ? MAX16 : i_target;
  assign sum       = {1'b0, o_value} + {1'b0, stp};

  // Saturating moves: never step past tgt (ramp) or below MIN_VALUE (stop).
  always_comb begin
    ramp_val = tgt;
    if (o_value < tgt) begin
      if (sum < {1'b0, tgt}) ramp_val = sum[15:0];
    end else if ((o_value - tgt) > stp) begin
      ramp_val = o_value - stp;
    end
  end

  assign stop_val = ((o_value - MIN16) > stp) ? (o_value - stp) : MIN16;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_RAMP;
      S_RAMP: begin
        if (i_stop)                              state_nxt = S_STOP;
        else if (i_start)                        state_nxt = S_RAMP;
        else if (o_value == tgt)                 state_nxt = S_RUN;
        else if (step_hit && (ramp_val == tgt))  state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_stop)       state_nxt = S_STOP;
        else if (i_start) state_nxt = S_RAMP;
      end
      S_STOP: if (step_hit && (o_value == MIN16)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; a retarget cycle does not also step,
  // so a stale direction can never overshoot the new target.
  always_comb begin
    value_nxt = o_value;
    en_nxt    = o_en;
    done_nxt  = 1'b0;
    tgt_nxt   = tgt;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          value_nxt = MIN16;
          en_nxt    = 1'b1;
          tgt_nxt   = tgt_clamp;
        end
      end
      S_RAMP: begin
        if (!i_stop) begin
          if (i_start)       tgt_nxt   = tgt_clamp;
          else if (step_hit) value_nxt = ramp_val;
        end
      end
      S_RUN: if (!i_stop && i_start) tgt_nxt = tgt_clamp;
      S_STOP: begin
        if (step_hit) begin
          if (o_value == MIN16) begin
            value_nxt = 16'd0;
            en_nxt    = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            value_nxt = stop_val;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt        <= '0;
      tgt        <= MIN16;
      o_value    <= '0;
      o_en       <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_at_speed <= 1'b0;
    end else begin
      if ((state == S_IDLE) || (state_nxt != state) || step_hit) cnt <= '0;
      else                                                       cnt <= cnt + 24'd1;
      tgt        <= tgt_nxt;
      o_value    <= value_nxt;
      o_en       <= en_nxt;
      o_done     <= done_nxt;
      o_busy     <= (state_nxt != S_IDLE);
      o_at_speed <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
module tb_motor_ramp_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start, i_stop;
  logic [15:0] i_target, i_step;
  logic        o_en, o_busy, o_at_speed, o_done;
  logic [15:0] o_value;

  int n_chk  = 0;
  int n_pass = 0;

  motor_ramp_ctrl #(.STEP_DIV(4), .MIN_VALUE(10), .MAX_VALUE(100)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_target(i_target), .i_step(i_step), .o_en(o_en), .o_value(o_value),
    .o_busy(o_busy), .o_at_speed(o_at_speed), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic pulse_start(input logic [15:0] t);
    i_target = t;
    i_start  = 1'b1;
    @(negedge i_clk);
    i_start  = 1'b0;
  endtask

  task automatic pulse_stop();
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
  endtask

  // Value must stay at prev for three clocks and reach nxt on the fourth.
  task automatic expect_step(input logic [15:0] prev, input logic [15:0] nxt);
    repeat (3) @(negedge i_clk);
    chk("step_hold", o_value, prev);
    @(negedge i_clk);
    chk("step_move", o_value, nxt);
  endtask

  task automatic wait_value(input logic [15:0] v, input int budget);
    int n = 0;
    while (o_value != v && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("wait_value", o_value, v);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("done_seen", o_done, 1);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_target = '0; i_step = 16'd8;
    repeat (3) @(negedge i_clk);
    chk("rst_en", o_en, 0);
    chk("rst_value", o_value, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_at_speed", o_at_speed, 0);
    chk("rst_done", o_done, 0);
    i_rst = 1'b0;

    pulse_stop();
    chk("idle_stop_ignored", o_busy, 0);

    // ramp up 10,18,26,30
    pulse_start(16'd30);
    chk("start_value", o_value, 10);
    chk("start_en", o_en, 1);
    chk("start_busy", o_busy, 1);
    chk("start_at_speed", o_at_speed, 0);
    expect_step(16'd10, 16'd18);
    expect_step(16'd18, 16'd26);
    expect_step(16'd26, 16'd30);
    chk("run_at_speed", o_at_speed, 1);
    repeat (6) @(negedge i_clk);
    chk("run_hold", o_value, 30);

    // stop 22,14,10 then idle
    pulse_stop();
    chk("stop_at_speed", o_at_speed, 0);
    chk("stop_busy", o_busy, 1);
    expect_step(16'd30, 16'd22);
    expect_step(16'd22, 16'd14);
    expect_step(16'd14, 16'd10);
    repeat (3) @(negedge i_clk);
    chk("stop_min_hold", o_value, 10);
    chk("stop_no_early_done", o_done, 0);
    @(negedge i_clk);
    chk("stop_done", o_done, 1);
    chk("stop_en", o_en, 0);
    chk("stop_value", o_value, 0);
    chk("stop_busy_low", o_busy, 0);
    @(negedge i_clk);
    chk("done_one_cycle", o_done, 0);

    // clamp high with zero step
    i_step = 16'd0;
    pulse_start(16'd500);
    expect_step(16'd10, 16'd11);
    expect_step(16'd11, 16'd12);
    wait_value(16'd100, 400);
    chk("clamp_at_speed", o_at_speed, 1);
    repeat (8) @(negedge i_clk);
    chk("clamp_hold", o_value, 100);

    i_step = 16'd200;
    pulse_stop();
    wait_done(20);
    chk("big_stop_en", o_en, 0);

    // clamp low: already at target, RUN on next edge without a step
    pulse_start(16'd0);
    chk("low_value", o_value, 10);
    chk("low_ramp", o_at_speed, 0);
    @(negedge i_clk);
    chk("low_run", o_at_speed, 1);
    chk("low_value_run", o_value, 10);

    // retarget up to 60, then down to 20
    i_step = 16'd50;
    pulse_start(16'd60);
    expect_step(16'd10, 16'd60);
    chk("up60_at_speed", o_at_speed, 1);
    i_step = 16'd15;
    pulse_start(16'd20);
    chk("retgt_drop", o_at_speed, 0);
    chk("retgt_value", o_value, 60);
    expect_step(16'd60, 16'd45);
    expect_step(16'd45, 16'd30);
    expect_step(16'd30, 16'd20);
    chk("retgt_at_speed", o_at_speed, 1);

    // simultaneous start/stop: stop wins; start in STOP ignored
    i_target = 16'd90; i_start = 1'b1; i_stop = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_stop = 1'b0;
    chk("simul_at_speed", o_at_speed, 0);
    chk("simul_busy", o_busy, 1);
    pulse_start(16'd90);
    repeat (2) @(negedge i_clk);
    chk("stop_start_hold", o_value, 20);
    @(negedge i_clk);
    chk("stop_start_ignored", o_value, 10);
    wait_done(10);

    // async reset mid-ramp
    i_step = 16'd8;
    @(negedge i_clk);
    pulse_start(16'd90);
    repeat (6) @(negedge i_clk);
    chk("pre_rst_value", o_value, 18);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_en", o_en, 0);
    chk("arst_value", o_value, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("post_rst_done", o_done, 0);
    pulse_start(16'd50);
    chk("restart_value", o_value, 10);
    chk("restart_done", o_done, 0);
    expect_step(16'd10, 16'd18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
